tx_clk_reset_seq: RTL
=====================

Name: tx_clk_reset_seq

Overview:
- Transmit-side clock/reset manager for the 10G MAC TX path.
- Drives the reset of the TX clocking DCM and watches its asynchronous lock indication.
- Holds the TX datapath in reset until lock has been stable for a programmed time, and recovers automatically from lock loss or lock timeout.
- Runs on the DCM reference input clock, so it keeps operating while the DCM output clocks are unstable.

Parameters:
- DCM_RST_CYCLES, 3: cycles dcm_rst is held high per DCM reset attempt (minimum 3).
- LOCK_TIMEOUT, 65535: cycles to wait for lock before re-resetting the DCM.
- STABLE_CYCLES, 256: consecutive synchronized-lock cycles required before TX release.
- SYNC_STAGES, 2: flops in the dcm_locked synchronizer (minimum 2).

Ports:
- txclk_in, input, 1: reference clock; the only clock.
- reset, input, 1: synchronous, active-high reset.
- dcm_locked, input, 1: asynchronous lock indication from the TX DCM.
- clr_status, input, 1: single-cycle pulse that clears lock_lost and relock_count.
- dcm_rst, output, 1: reset to the TX DCM.
- tx_reset, output, 1: reset to the TX datapath; high whenever TX is not ready.
- tx_ready, output, 1: TX clocks valid and stable.
- lock_lost, output, 1: sticky flag, lock dropped while in RUN.
- relock_count, output, 8: saturating count of RUN-to-lock-loss events.

Behaviour:
- Synchronizer:
  - locked_s is dcm_locked passed through SYNC_STAGES flops.
  - The synchronizer flops reset to 0.
  - The FSM uses only locked_s.
- Counter: cnt is one shared counter, wide enough for max(LOCK_TIMEOUT, STABLE_CYCLES, DCM_RST_CYCLES).
- FSM states: RST_DCM, WAIT_LOCK, STABILIZE, RUN. All outputs are registered or decoded directly from the state register.
- On reset:
  - state=RST_DCM, cnt=0, dcm_rst=1, tx_reset=1, tx_ready=0.
  - lock_lost=0, relock_count=0, synchronizer flops=0.
- RST_DCM:
  - dcm_rst=1.
  - When cnt==DCM_RST_CYCLES-1, go to WAIT_LOCK with cnt=0. Otherwise cnt++.
- WAIT_LOCK:
  - dcm_rst=0.
  - If locked_s=1, go to STABILIZE with cnt=0.
  - Else if cnt==LOCK_TIMEOUT-1, go to RST_DCM with cnt=0.
  - Else cnt++.
- STABILIZE:
  - If locked_s=0, go to WAIT_LOCK with cnt=0. No DCM reset.
  - Else if cnt==STABLE_CYCLES-1, go to RUN.
  - Else cnt++.
  - STABILIZE therefore lasts exactly STABLE_CYCLES cycles.
- RUN:
  - tx_ready=1, tx_reset=0.
  - If locked_s=0, go to RST_DCM with cnt=0, set lock_lost=1, and increment relock_count, saturating at 255.
- Output decode: tx_ready=(state==RUN) and tx_reset=!(state==RUN), both registered with the state.
- Release latency: if dcm_locked is first sampled 1 at edge E0 while in WAIT_LOCK, tx_ready rises after edge E0+SYNC_STAGES+STABLE_CYCLES.
- Lock-loss latency: tx_reset re-asserts SYNC_STAGES+1 edges after dcm_locked falls.
- clr_status:
  - Clears lock_lost and relock_count to 0.
  - If clr_status coincides with a lock-loss event, the set wins: lock_lost=1, relock_count=1.
  - clr_status has no effect on the FSM.
- Glitch handling: a lock glitch shorter than one cycle may be missed. Any sampled drop in STABILIZE restarts the stability count.
- Reset mid-operation: reset in any state returns to the reset values on the next edge, and the DCM is reset again.
- Timeout retry: the module retries indefinitely with no retry limit; each timeout re-enters RST_DCM.

Decomposition:
- Shared package holds:
  - the FSM state encoding constants (2-bit: RST_DCM=0, WAIT_LOCK=1, STABILIZE=2, RUN=3);
  - the default timing constants.
- One natural sub-module, sync_bit: a parameterized SYNC_STAGES flop chain with synchronous reset. The rx clocking block reuses it.

Test Plan:
- Power-up with params DCM_RST_CYCLES=3, LOCK_TIMEOUT=100, STABLE_CYCLES=16, SYNC_STAGES=2:
  - Release reset, raise dcm_locked at edge 10.
  - Expect dcm_rst high for edges 1-3.
  - Expect tx_ready=1 and tx_reset=0 after edge 28.
- Lock timeout: hold dcm_locked=0.
  - Expect dcm_rst to re-pulse for 3 cycles every 103 cycles.
  - tx_ready stays 0; lock_lost stays 0.
- Unstable lock: raise dcm_locked, drop it for 2 cycles after 10 cycles of STABILIZE, then hold it high.
  - Expect the FSM to return to WAIT_LOCK with no dcm_rst pulse.
  - Expect tx_ready only after a fresh 16-cycle window.
- Lock loss in RUN: drop dcm_locked.
  - Expect tx_reset=1 three edges later, dcm_rst pulse, lock_lost=1, relock_count=1.
  - Repeat the loss 300 times: relock_count saturates at 255.
- clr_status pulsed in the same cycle as a lock-loss detection: expect lock_lost=1, relock_count=1. A later lone pulse clears both to 0.
- Synchronous reset asserted while in RUN: expect the next edge to give tx_ready=0, tx_reset=1, dcm_rst=1, counters 0, then a full re-lock sequence.

Source files
------------

// File: rtl/tx_clk_reset_seq_pkg.sv
// ----------------------------------------------------------------------------
// tx_clk_reset_seq_pkg : state encoding and default timing for the TX clk/rst manager
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package tx_clk_reset_seq_pkg;

  typedef enum logic [1:0] {
    ST_RST_DCM   = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_STABILIZE = 2'd2,
    ST_RUN       = 2'd3
  } tx_state_e;

  localparam int DEF_DCM_RST_CYCLES = 3;
  localparam int DEF_LOCK_TIMEOUT   = 65535;
  localparam int DEF_STABLE_CYCLES  = 256;
  localparam int DEF_SYNC_STAGES    = 2;
  localparam logic [7:0] RELOCK_MAX = 8'hFF;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_bit.sv
// ----------------------------------------------------------------------------
// sync_bit : STAGES-deep single-bit synchronizer with synchronous reset to 0
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/tx_clk_reset_seq.sv
// ----------------------------------------------------------------------------
// tx_clk_reset_seq : resets the TX DCM, qualifies its lock and releases the TX datapath
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tx_clk_reset_seq
  import tx_clk_reset_seq_pkg::*;
#(
  parameter int DCM_RST_CYCLES = DEF_DCM_RST_CYCLES,
  parameter int LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
  parameter int STABLE_CYCLES  = DEF_STABLE_CYCLES,
  parameter int SYNC_STAGES    = DEF_SYNC_STAGES
) (
  input  logic       txclk_in,
  input  logic       reset,
  input  logic       dcm_locked,
  input  logic       clr_status,
  output logic       dcm_rst,
  output logic       tx_reset,
  output logic       tx_ready,
  output logic       lock_lost,
  output logic [7:0] relock_count
);

  localparam int CNT_MAX = max3(LOCK_TIMEOUT, STABLE_CYCLES, DCM_RST_CYCLES);
  localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] DCM_RST_LAST = CNT_W'(DCM_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  logic             locked_s;
  tx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lock_loss;
  logic             dcm_rst_q, dcm_rst_d;
  logic             tx_reset_q, tx_reset_d;
  logic             tx_ready_q, tx_ready_d;
  logic             lock_lost_q, lock_lost_d;
  logic [7:0]       relock_count_q, relock_count_d;

  sync_bit #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk (txclk_in),
    .rst (reset),
    .d   (dcm_locked),
    .q   (locked_s)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    lock_loss = 1'b0;
    unique case (state_q)
      ST_RST_DCM: begin
        if (cnt_q == DCM_RST_LAST) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_WAIT_LOCK: begin
        // A lock seen on the final timeout cycle still wins over the re-reset.
        if (locked_s) begin
          state_d = ST_STABILIZE;
          cnt_d   = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d = ST_RST_DCM;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_STABILIZE: begin
        if (!locked_s) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_RUN: begin
        if (!locked_s) begin
          state_d   = ST_RST_DCM;
          cnt_d     = '0;
          lock_loss = 1'b1;
        end
      end
      default: begin
        state_d = ST_RST_DCM;
        cnt_d   = '0;
      end
    endcase
  end

  // A lock-loss event in the same cycle as clr_status takes precedence.
  always_comb begin
    lock_lost_d    = lock_lost_q;
    relock_count_d = relock_count_q;
    if (lock_loss) begin
      lock_lost_d = 1'b1;
      if (clr_status) begin
        relock_count_d = 8'd1;
      end else if (relock_count_q != RELOCK_MAX) begin
        relock_count_d = relock_count_q + 8'd1;
      end
    end else if (clr_status) begin
      lock_lost_d    = 1'b0;
      relock_count_d = 8'd0;
    end
  end

  always_comb begin
    dcm_rst_d  = (state_d == ST_RST_DCM);
    tx_ready_d = (state_d == ST_RUN);
    tx_reset_d = (state_d != ST_RUN);
  end

  always_ff @(posedge txclk_in) begin
    if (reset) begin
      state_q        <= ST_RST_DCM;
      cnt_q          <= '0;
      dcm_rst_q      <= 1'b1;
      tx_reset_q     <= 1'b1;
      tx_ready_q     <= 1'b0;
      lock_lost_q    <= 1'b0;
      relock_count_q <= 8'd0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      dcm_rst_q      <= dcm_rst_d;
      tx_reset_q     <= tx_reset_d;
      tx_ready_q     <= tx_ready_d;
      lock_lost_q    <= lock_lost_d;
      relock_count_q <= relock_count_d;
    end
  end

  assign dcm_rst      = dcm_rst_q;
  assign tx_reset     = tx_reset_q;
  assign tx_ready     = tx_ready_q;
  assign lock_lost    = lock_lost_q;
  assign relock_count = relock_count_q;

endmodule

`default_nettype wire
